// File: rtl/spi_top.sv
// Wishbone-slave SPI master: up to MAX_CHAR-bit full-duplex shifts, programmable
// sclk divider, selectable edges and bit order, SS_NB active-low selects and a done interrupt.
module spi_top #(
  parameter int SS_NB    = 8,
  parameter int MAX_CHAR = 128,
  parameter int DIV_LEN  = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [4:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_int_o,
  output logic [SS_NB-1:0] ss_pad_o,
  output logic             sclk_pad_o,
  output logic             mosi_pad_o,
  input  logic             miso_pad_i
);
  localparam int WORDS = MAX_CHAR / 32;
  localparam int IW    = $clog2(MAX_CHAR);
  localparam int CW    = IW + 1;

  logic [MAX_CHAR-1:0] data_reg;
  logic [13:0]         ctrl_reg;
  logic [DIV_LEN-1:0]  div_reg, cnt_reg;
  logic [SS_NB-1:0]    ss_reg;
  logic [31:0]         dat_o_reg;
  logic                ack_reg, int_reg, sclk_reg, mosi_reg;
  logic [CW-1:0]       tx_cnt_reg, rx_cnt_reg;

  logic        busy, rx_neg, tx_neg, lsb, ie, ass;
  logic        req, wr, go, tick, rise, fall, tx_edge, rx_edge, last;
  logic [2:0]  word;
  logic [31:0] wmask, ctrl_wr, div_wr, ss_wr, rd_data;
  logic [13:0] ctrl_next;
  logic [CW-1:0] len, len_next;
  logic        unused_bits;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wmask[gi*8 +: 8] = {8{wb_sel_i[gi]}};
    end
  endgenerate

  function automatic logic [CW-1:0] char_len(input logic [6:0] f);
    return (f == 7'd0) ? CW'(MAX_CHAR) : CW'(f);
  endfunction

  // Register position of the n-th bit on the wire; received bit n lands where
  // transmitted bit n came from, so DATA ends up in transmitted bit order.
  function automatic logic [IW-1:0] bit_pos(input logic [CW-1:0] n, input logic [CW-1:0] l,
                                            input logic lsb_first);
    logic [CW-1:0] p;
    p = lsb_first ? n : (l - CW'(1) - n);
    return p[IW-1:0];
  endfunction

  always_comb begin
    busy      = ctrl_reg[8];
    rx_neg    = ctrl_reg[9];
    tx_neg    = ctrl_reg[10];
    lsb       = ctrl_reg[11];
    ie        = ctrl_reg[12];
    ass       = ctrl_reg[13];
    req       = wb_stb_i & wb_cyc_i & ~ack_reg;
    wr        = req & wb_we_i;
    word      = wb_adr_i[4:2];
    ctrl_wr   = (32'(ctrl_reg) & ~wmask) | (wb_dat_i & wmask);
    div_wr    = (32'(div_reg) & ~wmask) | (wb_dat_i & wmask);
    ss_wr     = (32'(ss_reg) & ~wmask) | (wb_dat_i & wmask);
    ctrl_next = {ctrl_wr[13:8], 1'b0, ctrl_wr[6:0]};
    go        = wr && (word == 3'd4) && !busy && ctrl_next[8];
    len       = char_len(ctrl_reg[6:0]);
    len_next  = char_len(ctrl_next[6:0]);
    tick      = busy && (cnt_reg == '0);
    rise      = tick && !sclk_reg;
    fall      = tick && sclk_reg;
    tx_edge   = tx_neg ? fall : rise;
    rx_edge   = rx_neg ? fall : rise;
    // The transfer always ends on the len-th falling edge so sclk idles low.
    last      = fall && (rx_cnt_reg == (rx_neg ? (len - CW'(1)) : len));
    rd_data   = '0;
    case (word)
      3'd4:    rd_data = 32'(ctrl_reg);
      3'd5:    rd_data = 32'(div_reg);
      3'd6:    rd_data = 32'(ss_reg);
      default: begin
        for (int w = 0; w < WORDS; w++)
          if (word == 3'(w)) rd_data = data_reg[w*32 +: 32];
      end
    endcase
    unused_bits = &{1'b0, wb_adr_i[1:0], ctrl_wr[31:14], ctrl_wr[7], div_wr, ss_wr};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      data_reg   <= '0;
      ctrl_reg   <= '0;
      div_reg    <= '0;
      cnt_reg    <= '0;
      ss_reg     <= '0;
      dat_o_reg  <= '0;
      ack_reg    <= 1'b0;
      int_reg    <= 1'b0;
      sclk_reg   <= 1'b0;
      mosi_reg   <= 1'b0;
      tx_cnt_reg <= '0;
      rx_cnt_reg <= '0;
    end else begin
      ack_reg <= req;
      if (req) dat_o_reg <= rd_data;
      if (ack_reg) int_reg <= 1'b0;
      if (wr && word == 3'd6) ss_reg <= ss_wr[SS_NB-1:0];
      if (wr && !busy && word == 3'd5) div_reg <= div_wr[DIV_LEN-1:0];
      if (wr && !busy && word == 3'd4) ctrl_reg <= ctrl_next;
      for (int w = 0; w < WORDS; w++)
        if (wr && !busy && word == 3'(w))
          data_reg[w*32 +: 32] <= (data_reg[w*32 +: 32] & ~wmask) | (wb_dat_i & wmask);

      if (go) begin
        // First bit goes out right away; with TX_NEG=0 the first rising edge re-drives it.
        cnt_reg    <= div_reg;
        sclk_reg   <= 1'b0;
        rx_cnt_reg <= '0;
        tx_cnt_reg <= ctrl_next[10] ? CW'(1) : CW'(0);
        mosi_reg   <= data_reg[bit_pos(CW'(0), len_next, ctrl_next[11])];
      end else if (busy) begin
        cnt_reg <= tick ? div_reg : (cnt_reg - DIV_LEN'(1));
        if (tick) sclk_reg <= ~sclk_reg;
        if (tx_edge && tx_cnt_reg < len) begin
          mosi_reg   <= data_reg[bit_pos(tx_cnt_reg, len, lsb)];
          tx_cnt_reg <= tx_cnt_reg + CW'(1);
        end
        if (rx_edge && rx_cnt_reg < len) begin
          data_reg[bit_pos(rx_cnt_reg, len, lsb)] <= miso_pad_i;
          rx_cnt_reg <= rx_cnt_reg + CW'(1);
        end
        if (last) begin
          ctrl_reg[8] <= 1'b0;
          if (ie) int_reg <= 1'b1;
        end
      end
    end
  end

  assign wb_dat_o   = dat_o_reg;
  assign wb_ack_o   = ack_reg;
  assign wb_err_o   = 1'b0;
  assign wb_int_o   = int_reg;
  assign sclk_pad_o = sclk_reg;
  assign mosi_pad_o = mosi_reg;
  assign ss_pad_o   = ~(ss_reg & (ass ? {SS_NB{busy}} : {SS_NB{1'b1}}));
endmodule

// File: tb/tb_spi_top.sv
// Self-checking bench for spi_top: register access, loopback and external-slave
// transfers, bit order/edge options, interrupt, auto slave select, busy lock, reset abort.
module tb_spi_top;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  adr;
  logic [31:0] dat_i, dat_o;
  logic [3:0]  sel;
  logic        we, stb, cyc, ack, err, irq;
  logic [7:0]  ss;
  logic        sclk, mosi, miso, lb, ext;

  always #5 clk = ~clk;
  assign miso = lb ? mosi : ext;

  spi_top dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack),
    .wb_err_o(err), .wb_int_o(irq), .ss_pad_o(ss), .sclk_pad_o(sclk), .mosi_pad_o(mosi),
    .miso_pad_i(miso)
  );

  int vectors = 0, miscompares = 0;
  int cyc_cnt = 0, rise_cnt = 0, rise_c1 = 0, rise_c2 = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(posedge sclk) begin
    rise_cnt++;
    if (rise_cnt == 1) rise_c1 = cyc_cnt;
    else if (rise_cnt == 2) rise_c2 = cyc_cnt;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic [4:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r, output int lat, output logic ack_tail);
    @(negedge clk);
    adr = a; we = w; dat_i = d; sel = s; stb = 1'b1; cyc = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack && lat < 16);
    r = dat_o;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    ack_tail = ack;
  endtask

  // ack must arrive after exactly one wait state and stay high a single cycle: {lat, tail} == 2
  task automatic wr(input string tag, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    int lat;
    logic tail;
    bus(a, 1'b1, d, s, r, lat, tail);
    $display("WR %-12s adr=0x%02h dat=0x%08h sel=%b", tag, a, d, s);
    check_val({tag, " ack"}, {23'd0, lat[7:0], tail}, 32'h2);
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] e);
    logic [31:0] r;
    int lat;
    logic tail;
    exp_q.push_back(e);
    bus(a, 1'b0, 32'd0, 4'hF, r, lat, tail);
    $display("RD %-12s adr=0x%02h dat=0x%08h", tag, a, r);
    check_val({tag, " ack"}, {23'd0, lat[7:0], tail}, 32'h2);
    check_val(tag, r, exp_q.pop_front());
  endtask

  task automatic wait_idle(input string tag, output int done_cyc);
    logic [31:0] r;
    int lat;
    logic tail;
    r = 32'hFFFF_FFFF;
    for (int i = 0; i < 150; i++) begin
      bus(5'h10, 1'b0, 32'd0, 4'hF, r, lat, tail);
      if (!r[8]) break;
    end
    done_cyc = cyc_cnt;
    check_val({tag, " idle"}, 32'(r[8]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int go_cyc, done_cyc, n;
    adr = '0; dat_i = '0; sel = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0; lb = 1'b1; ext = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst sclk", 32'(sclk), 32'd0);
    check_val("rst mosi", 32'(mosi), 32'd0);
    check_val("rst ss", 32'(ss), 32'hFF);
    check_val("rst int", 32'(irq), 32'd0);
    check_val("rst ack", 32'(ack), 32'd0);
    check_val("rst err", 32'(err), 32'd0);
    rst_n = 1'b1;
    rd("rst ctrl", 5'h10, 32'h0);
    rd("rst div", 5'h14, 32'h0);
    rd("rst data0", 5'h00, 32'h0);

    // register access
    wr("div", 5'h14, 32'h1, 4'hF);
    wr("data0", 5'h00, 32'h0080_0950, 4'hF);
    wr("data1", 5'h04, 32'hCAFE_F00D, 4'hF);
    wr("ctrl", 5'h10, 32'h218, 4'hF);
    wr("ss", 5'h18, 32'h1, 4'hF);
    rd("rb div", 5'h14, 32'h1);
    rd("rb data0", 5'h00, 32'h0080_0950);
    rd("rb ctrl", 5'h10, 32'h218);
    rd("rb ss", 5'h18, 32'h1);
    check_val("ss pads", 32'(ss), 32'hFE);
    wr("div lane0", 5'h14, 32'hABCD, 4'b0001);
    rd("rb div lane0", 5'h14, 32'hCD);
    wr("div", 5'h14, 32'h1, 4'hF);
    wr("unmapped", 5'h1C, 32'h1234, 4'hF);
    rd("unmapped", 5'h1C, 32'h0);

    // 24-bit MSB-first loopback, busy lock on DATA
    lb = 1'b1;
    rise_cnt = 0;
    wr("go lb24", 5'h10, 32'h318, 4'hF);
    go_cyc = cyc_cnt;
    rd("lb24 busy", 5'h10, 32'h318);
    wr("locked data0", 5'h00, 32'hFFFF_FFFF, 4'hF);
    check_val("lb24 ss", 32'(ss), 32'hFE);
    wait_idle("lb24", done_cyc);
    check_val("lb24 duration", 32'((done_cyc - go_cyc) >= 92 && (done_cyc - go_cyc) <= 106), 32'd1);
    check_val("lb24 rises", 32'(rise_cnt), 32'd24);
    check_val("lb24 period", 32'(rise_c2 - rise_c1), 32'd4);
    check_val("lb24 sclk idle", 32'(sclk), 32'd0);
    rd("lb24 data0", 5'h00, 32'h0080_0950);
    rd("lb24 data1", 5'h04, 32'hCAFE_F00D);
    rd("lb24 ctrl", 5'h10, 32'h218);

    // external slave drives miso=1, DIVIDER=0
    lb = 1'b0; ext = 1'b1;
    wr("div0", 5'h14, 32'h0, 4'hF);
    wr("data0 clr", 5'h00, 32'h0, 4'hF);
    rise_cnt = 0;
    wr("go ext8", 5'h10, 32'h108, 4'hF);
    wait_idle("ext8", done_cyc);
    rd("ext8 data0", 5'h00, 32'hFF);
    check_val("ext8 rises", 32'(rise_cnt), 32'd8);
    check_val("ext8 period", 32'(rise_c2 - rise_c1), 32'd2);
    rd("ext8 ctrl", 5'h10, 32'h008);

    // LSB-first, TX on falling / RX on rising, loopback
    lb = 1'b1;
    wr("div", 5'h14, 32'h1, 4'hF);
    wr("data0", 5'h00, 32'h1, 4'hF);
    wr("go lsb8", 5'h10, 32'hD08, 4'hF);
    check_val("lsb8 first mosi", 32'(mosi), 32'd1);
    check_val("lsb8 sclk pre", 32'(sclk), 32'd0);
    wait_idle("lsb8", done_cyc);
    rd("lsb8 data0", 5'h00, 32'h1);

    // interrupt and automatic slave select
    lb = 1'b0; ext = 1'b0;
    wr("data0", 5'h00, 32'hA5, 4'hF);
    wr("ss", 5'h18, 32'h4, 4'hF);
    check_val("ss manual", 32'(ss), 32'hFB);
    wr("go irq8", 5'h10, 32'h3108, 4'hF);
    check_val("irq8 ss busy", 32'(ss), 32'hFB);
    check_val("irq8 int busy", 32'(irq), 32'd0);
    n = 0;
    while (!irq && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val("irq8 int set", 32'(irq), 32'd1);
    check_val("irq8 ss idle", 32'(ss), 32'hFF);
    rd("irq8 ctrl", 5'h10, 32'h3008);
    check_val("irq8 int clr", 32'(irq), 32'd0);
    rd("irq8 data0", 5'h00, 32'h0);

    // asynchronous reset in the middle of a transfer
    wr("ss", 5'h18, 32'h1, 4'hF);
    wr("go abort", 5'h10, 32'h318, 4'hF);
    n = 0;
    while (!sclk && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("abort sclk high", 32'(sclk), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("abort sclk", 32'(sclk), 32'd0);
    check_val("abort ss", 32'(ss), 32'hFF);
    check_val("abort mosi", 32'(mosi), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd("abort ctrl", 5'h10, 32'h0);
    rd("abort ss reg", 5'h18, 32'h0);
    rd("abort div", 5'h14, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
